// File: rtl/priority_sched_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// priority_sched_ctrl_pkg
//   Shared definitions for the priority scheduler controller:
//     - requester count (fixed at four)
//     - default starvation and timeout constants
//     - controller state encoding
//     - one-hot decode helper used for the completion pulse
// ---------------------------------------------------------------------------
package priority_sched_ctrl_pkg;

    localparam int NREQ           = 4;
    localparam int STARVE_MAX_DEF = 3;
    localparam int TIMEOUT_DEF    = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/priority_sched_ctrl_pick.sv
// ---------------------------------------------------------------------------
// sched_pick
//   Combinational 4:2 winner select.
//   A starved requester always wins, lowest starved index first; otherwise
//   the highest requesting index wins (index 3 has top priority).
//   Ports:
//     req     in  [3:0]  active requests
//     starved in  [3:0]  requesters whose age has reached the promotion limit
//     idx     out [1:0]  winning index (0 when valid is low)
//     valid   out        at least one request present
// ---------------------------------------------------------------------------
module sched_pick
    import priority_sched_ctrl_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] starved,
    output logic [1:0]      idx,
    output logic            valid
);

    logic [NREQ-1:0] starved_req;

    // A starved flag without a live request must never steal the grant.
    assign starved_req = starved & req;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        idx   = '0;
        valid = |req;
        if (|starved_req) begin
            // Descending scan: the last hit is the lowest starved index.
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (starved_req[i]) idx = 2'(i);
            end
        end else begin
            // Ascending scan: the last hit is the highest requesting index.
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) idx = 2'(i);
            end
        end
    end

endmodule

// File: rtl/priority_sched_ctrl.sv
// ---------------------------------------------------------------------------
// priority_sched_ctrl
//   Four-requester scheduler in front of a single processing unit.
//   IDLE -> ARB (pick winner, latch its data) -> ISSUE (start strobe)
//   -> WAIT (completion or timeout) -> IDLE.
//   Losing requesters age; one that has lost STARVE_MAX arbitrations is
//   promoted above the fixed priority order.
//   Parameters:
//     DW          data width per requester
//     STARVE_MAX  lost arbitrations before promotion (1..3)
//     TIMEOUT     WAIT cycles tolerated before abort
//   Ports:
//     clk       in            rising-edge clock
//     rst       in            asynchronous active-high reset
//     req       in  [3:0]     level request per requester, held until ack
//     din       in  [4*DW-1:0] requester data, requester n at [n*DW +: DW]
//     ack       out [3:0]     one-cycle completion pulse to granted requester
//     dp_start  out           one-cycle issue strobe to the processing unit
//     dp_sel    out [1:0]     index of the granted requester
//     dp_data   out [DW-1:0]  latched data of the granted requester
//     dp_done   in            completion pulse from the processing unit
//     busy      out           high in every state except IDLE
//     err       out           one-cycle timeout pulse
// ---------------------------------------------------------------------------
module priority_sched_ctrl
    import priority_sched_ctrl_pkg::*;
#(
    parameter int DW         = 8,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]   ack,
    output logic              dp_start,
    output logic [1:0]        dp_sel,
    output logic [DW-1:0]     dp_data,
    input  logic              dp_done,
    output logic              busy,
    output logic              err
);

    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic [1:0]      AGE_MAX = 2'(STARVE_MAX);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT);

    state_t                 state;
    state_t                 state_nxt;
    logic [NREQ-1:0][1:0]   age;
    logic [NREQ-1:0]        starved;
    logic [1:0]             pick_idx;
    logic                   pick_valid;
    logic [TW-1:0]          tcnt;
    logic                   timeout_hit;

    // ---------------------------------------------------------------------
    // Winner select
    // ---------------------------------------------------------------------
    always_comb begin
        starved = '0;
        for (int i = 0; i < NREQ; i++) begin
            starved[i] = req[i] && (age[i] == AGE_MAX);
        end
    end

    sched_pick u_pick (
        .req     (req),
        .starved (starved),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    // ---------------------------------------------------------------------
    // Controller FSM
    // ---------------------------------------------------------------------
    // Counter saturates at TIMEOUT, so WAIT lasts TIMEOUT+1 cycles at most.
    assign timeout_hit = (tcnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (|req) state_nxt = ST_ARB;
            // Request withdrawn between IDLE and ARB: back out with no grant.
            ST_ARB:   state_nxt = pick_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (dp_done || timeout_hit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: all clocked state below uses non-blocking assignments so every
    // register sees pre-edge values of the others, independent of ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Decoded straight from the state register; reset forces IDLE, which
    // drives both low without any extra gating.
    assign dp_start = (state == ST_ISSUE);
    assign busy     = (state != ST_IDLE);

    // ---------------------------------------------------------------------
    // Grant datapath: selected index and data, stable until the next grant
    // ---------------------------------------------------------------------
    // NOTE: the data register is reset as well, because the interface
    // guarantees dp_data reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_sel  <= '0;
            dp_data <= '0;
        end else if (state == ST_ARB && pick_valid) begin
            dp_sel  <= pick_idx;
            dp_data <= din[pick_idx*DW +: DW];
        end
    end

    // ---------------------------------------------------------------------
    // Age counters: only move on an ARB cycle that actually grants
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (state == ST_ARB && pick_valid) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || pick_idx == 2'(i)) begin
                    age[i] <= '0;
                end else if (age[i] != AGE_MAX) begin
                    age[i] <= age[i] + 2'd1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // WAIT timer and completion / error pulses
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
            ack  <= '0;
            err  <= 1'b0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            if (state == ST_ISSUE) begin
                tcnt <= '0;
            end else if (state == ST_WAIT) begin
                // Completion wins over a timeout landing on the same cycle.
                if (dp_done) begin
                    ack <= onehot(dp_sel);
                end else if (timeout_hit) begin
                    err <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule
